sha256_block_feeder: RTL and testbench
======================================

// Module: sha256_block_feeder
// PURPOSE
//  Producer side of the SHA-256 core's block interface (data_in/start/done).
//  - Accepts a byte-oriented message as 32-bit big-endian words on a valid/ready stream.
//  - Packs the words into 512-bit blocks and applies FIPS 180-4 padding (0x80, zero fill, 64-bit bit length).
//  - Issues each block to the compression core and waits for its done before building the next.
// PARAMETERS
//  LEN_W  64  width of the message bit-length counter; upper (64-LEN_W) length bits are sent as 0
// PORTS
//  clk        in   1    clock, all state on rising edge
//  reset_n    in   1    asynchronous, active-low reset
//  s_data     in   32   message word; first byte in [31:24]
//  s_valid    in   1    s_data valid
//  s_ready    out  1    feeder accepts s_data this cycle (accept = s_valid & s_ready)
//  s_last     in   1    word is the final word of the message
//  s_bytes    in   2    valid bytes in final word: 0 = 4, 1..3 = 1..3; ignored unless s_last
//  blk_data   out  512  block to core; word i at [32*i +: 32], word 0 = first message word
//  blk_start  out  1    one-cycle pulse: blk_data valid, core begins compression
//  blk_first  out  1    qualifies blk_start: first block of message (core reloads H0..H7)
//  blk_last   out  1    qualifies blk_start: final block of message
//  blk_done   in   1    core pulse: block consumed, digest updated
//  msg_done   out  1    one-cycle pulse on blk_done of the final block
// BEHAVIOUR
//  Reset (async assert, sync deassert): state = FILL.
//   - widx = 0, bitlen = 0, first = 1.
//   - blk_data = 0; s_ready, blk_start, blk_first, blk_last and msg_done all 0.
//  States: FILL, PAD, SEND, WAIT, XPAD.
//  FILL: s_ready = 1. Each accept writes word widx and increments widx.
//   - bitlen += 32, or 8*s_bytes on s_last; bitlen wraps mod 2^LEN_W.
//   - Non-last accept at widx = 15 -> SEND.
//   - s_last accept at any widx -> PAD.
//  PAD (1 cycle): bytes beyond s_bytes in the last word are forced to 0.
//   - Place 0x80 at the next byte position. p = word index holding 0x80 (16 if the last word was full at widx = 15).
//   - p <= 13: zero words p+1..13; word14 = bitlen[63:32], word15 = bitlen[31:0]; mark final -> SEND.
//   - p >= 14: zero the remaining words of this block; block is not final; set xpad (and pend80 if p = 16) -> SEND.
//  SEND (1 cycle): blk_start = 1; blk_first = first; blk_last = final.
//   - Clear first -> WAIT.
//  WAIT: s_ready = 0; blk_data held stable until blk_done.
//   - On blk_done: final -> msg_done pulse, reset widx/bitlen/first/final -> FILL.
//   - Otherwise, if xpad -> XPAD; else widx = 0 -> FILL.
//  XPAD (1 cycle): block = zeros with bitlen in words 14/15.
//   - If pend80, word0 = 0x80000000. Mark final -> SEND.
//  Latency: a non-last 16th word accepted at cycle T gives blk_start at T+1.
//   - s_last accepted at T gives blk_start at T+2.
//   - blk_done of a non-final block at T gives s_ready at T+1 (FILL) or blk_start at T+2 (XPAD path).
//  blk_done outside WAIT is ignored. s_valid is ignored while s_ready = 0.
//  Zero-length messages are not supported (every message carries at least one byte).
//  Reset asserted mid-message aborts the message; no blk_start or msg_done is issued for it.
// TESTING
//  1 "abc": s_data=0x61626300, s_last=1, s_bytes=3 -> one block, word0=0x61626380, words1..14=0, word15=0x18.
//    blk_first = blk_last = 1; with the core, digest = ba7816bf...f20015ad.
//  2 56-byte message (14 words, last full) -> block 1 holds data plus word14=0x80000000, word15=0, blk_last=0.
//    Block 2 is all zero except word15=0x1C0, blk_last=1.
//  3 64-byte message -> block 1 = raw data; block 2 word0=0x80000000, word15=0x200.
//    blk_first only on block 1; one msg_done.
//  4 Backpressure: s_valid held high across a block -> s_ready=0 from SEND through WAIT.
//    No word lost or duplicated; blk_data constant until blk_done.
//  5 Reset pulse while in WAIT -> outputs zero immediately, next message starts with blk_first=1 and bitlen from 0.
//  6 Spurious blk_done during FILL, and s_bytes != 0 on a non-last word -> both ignored; block contents unchanged.

Source files
------------

// File: rtl/sha256_block_feeder.sv
// sha256_block_feeder
//   Producer side of a SHA-256 compression core's block interface. Packs a
//   byte-oriented message (32-bit big-endian words) into 512-bit blocks,
//   appends the standard padding (0x80, zero fill, 64-bit bit length) and
//   hands each block to the core, waiting for its done before continuing.
//
// Ports
//   clk, reset_n        clock (rising edge), async active-low reset
//   s_data/s_valid/     message word stream; first byte in [31:24]
//   s_ready/s_last/     s_bytes = valid bytes of the final word (0 means 4)
//   s_bytes
//   blk_data            512-bit block, word i at [32*i +: 32]
//   blk_start           one-cycle pulse, block valid, core begins
//   blk_first/blk_last  qualify blk_start: first / final block of message
//   blk_done            core pulse: block consumed
//   msg_done            one-cycle pulse on blk_done of the final block
module sha256_block_feeder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [31:0]  s_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         s_last,
    input  logic [1:0]   s_bytes,
    output logic [511:0] blk_data,
    output logic         blk_start,
    output logic         blk_first,
    output logic         blk_last,
    input  logic         blk_done,
    output logic         msg_done
);

    typedef enum logic [2:0] {FILL, PAD, SEND, WAIT, XPAD} state_t;

    state_t             state, state_nx;
    logic [4:0]         widx;
    logic [LEN_W-1:0]   bitlen, len_inc;
    logic [63:0]        len64;
    logic               first, final_q, xpad, pend80;
    logic [1:0]         lbytes;
    logic [15:0][31:0]  blk_q, pad_blk;
    logic               ready_q, accept;
    logic [4:0]         p;
    logic [3:0]         lw;
    logic [31:0]        mark;

    assign s_ready  = ready_q;
    assign blk_data = blk_q;
    assign accept   = ready_q & s_valid;

    // Length counter may be narrower than 64 bits; upper bits go out as 0.
    always_comb begin
        len64 = '0;
        len64[LEN_W-1:0] = bitlen;
    end

    always_comb begin
        len_inc = '0;
        if (s_last && s_bytes != 2'd0) len_inc[4:0] = {s_bytes, 3'b000};
        else                           len_inc[5:0] = 6'd32;
    end

    // Padding of the current block. p is the word that receives 0x80: the
    // last data word when it was partial, otherwise the word after it
    // (16 means the 0x80 spills into an extra block).
    always_comb begin
        lw   = 4'(widx - 5'd1);
        p    = (lbytes != 2'd0) ? {1'b0, lw} : widx;
        case (lbytes)
            2'd1:    mark = {blk_q[lw][31:24], 24'h800000};
            2'd2:    mark = {blk_q[lw][31:16], 16'h8000};
            2'd3:    mark = {blk_q[lw][31:8],  8'h80};
            default: mark = 32'h8000_0000;
        endcase
        pad_blk = blk_q;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) == p)     pad_blk[i] = mark;
            else if (5'(i) > p) pad_blk[i] = '0;
        end
        if (p <= 5'd13) begin
            pad_blk[14] = len64[63:32];
            pad_blk[15] = len64[31:0];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            FILL: if (accept) begin
                      if (s_last)                state_nx = PAD;
                      else if (widx == 5'd15)    state_nx = SEND;
                  end
            PAD:  state_nx = SEND;
            SEND: state_nx = WAIT;
            WAIT: if (blk_done) begin
                      if (final_q)   state_nx = FILL;
                      else if (xpad) state_nx = XPAD;
                      else           state_nx = FILL;
                  end
            XPAD: state_nx = SEND;
            default: state_nx = FILL;
        endcase
    end

    always_comb begin
        blk_start = 1'b0;
        blk_first = 1'b0;
        blk_last  = 1'b0;
        msg_done  = 1'b0;
        if (state == SEND) begin
            blk_start = 1'b1;
            blk_first = first;
            blk_last  = final_q;
        end
        if (state == WAIT && blk_done && final_q) msg_done = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= FILL;
            widx    <= '0;
            bitlen  <= '0;
            first   <= 1'b1;
            final_q <= 1'b0;
            xpad    <= 1'b0;
            pend80  <= 1'b0;
            lbytes  <= '0;
            blk_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nx;
            // Registered ready: high exactly while the FSM sits in FILL.
            ready_q <= (state_nx == FILL);
            case (state)
                FILL: if (accept) begin
                          blk_q[widx[3:0]] <= s_data;
                          widx   <= widx + 5'd1;
                          bitlen <= bitlen + len_inc;
                          lbytes <= s_last ? s_bytes : 2'd0;
                      end
                PAD: begin
                    blk_q <= pad_blk;
                    if (p <= 5'd13) final_q <= 1'b1;
                    else begin
                        xpad   <= 1'b1;
                        pend80 <= (p == 5'd16);
                    end
                end
                SEND: first <= 1'b0;
                WAIT: if (blk_done) begin
                          if (final_q) begin
                              widx    <= '0;
                              bitlen  <= '0;
                              first   <= 1'b1;
                              final_q <= 1'b0;
                          end else if (xpad) begin
                              xpad <= 1'b0;
                          end else begin
                              widx <= '0;
                          end
                      end
                XPAD: begin
                    blk_q     <= '0;
                    blk_q[0]  <= pend80 ? 32'h8000_0000 : 32'h0;
                    blk_q[14] <= len64[63:32];
                    blk_q[15] <= len64[31:0];
                    final_q   <= 1'b1;
                    pend80    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_feeder.sv
module tb_sha256_block_feeder;

    logic         clk = 0;
    logic         reset_n;
    logic [31:0]  s_data;
    logic         s_valid, s_ready, s_last;
    logic [1:0]   s_bytes;
    logic [511:0] blk_data;
    logic         blk_start, blk_first, blk_last, blk_done, msg_done;
    logic         core_done = 0, spur_done = 0, core_en = 1;

    assign blk_done = core_done | spur_done;

    sha256_block_feeder #(.LEN_W(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .s_last(s_last), .s_bytes(s_bytes),
        .blk_data(blk_data), .blk_start(blk_start),
        .blk_first(blk_first), .blk_last(blk_last),
        .blk_done(blk_done), .msg_done(msg_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] d;
        logic         f;
        logic         l;
    } exp_t;

    exp_t         exp_q[$];
    logic [31:0]  msg_q[$];
    logic [31:0]  ew[16];
    int           total = 0, passed = 0, msg_cnt = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h want %h", name, act, req);
    endtask

    task automatic push_exp(input logic f, input logic l);
        exp_t e;
        e.d = '0;
        for (int i = 0; i < 16; i++) e.d[32*i +: 32] = ew[i];
        e.f = f;
        e.l = l;
        exp_q.push_back(e);
        for (int i = 0; i < 16; i++) ew[i] = 32'h0;
    endtask

    // Core model: answers each block a few cycles after blk_start.
    initial begin
        forever begin
            @(negedge clk);
            if (blk_start && core_en) begin
                repeat (3) @(posedge clk);
                #1 core_done = 1;
                @(posedge clk);
                #1 core_done = 0;
            end
        end
    end

    // Monitor: pops expected block on every blk_start and checks hold-stability
    // of blk_data and s_ready=0 until the block's blk_done.
    logic         holding = 0, hold_ok = 0;
    logic [511:0] held;
    always @(negedge clk) begin
        if (!reset_n) begin
            holding = 0;
        end else begin
            if (msg_done) msg_cnt++;
            if (holding) begin
                if (blk_data !== held || s_ready !== 1'b0) hold_ok = 0;
                if (blk_done) begin
                    chk("wait_hold", {511'b0, hold_ok}, 512'd1);
                    holding = 0;
                end
            end
            if (blk_start) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_block", {511'b0, blk_start}, 512'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("blk_data", blk_data, e.d);
                    chk("blk_flags", {510'b0, blk_first, blk_last}, {510'b0, e.f, e.l});
                    chk("ready_in_send", {511'b0, s_ready}, 512'd0);
                end
                holding = 1;
                hold_ok = 1;
                held    = blk_data;
            end
        end
    end

    // Streams msg_q with s_valid held high; junk s_bytes on non-last words.
    // spur: word index before which a spurious blk_done is pulsed (-1 none).
    task automatic send_msg(input logic [1:0] lastb, input logic [1:0] junkb, input int spur);
        int n;
        for (int i = 0; i < msg_q.size(); i++) begin
            if (i == spur) begin
                s_valid = 0;
                spur_done = 1;
                @(posedge clk);
                #1 spur_done = 0;
            end
            s_valid = 1;
            s_data  = msg_q[i];
            s_last  = (i == msg_q.size() - 1);
            s_bytes = s_last ? lastb : junkb;
            n = 0;
            @(negedge clk);
            while (!s_ready && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (n >= 500) begin
                chk("accept_timeout", 512'd1, 512'd0);
                break;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 0;
        s_last  = 0;
        s_bytes = 0;
        msg_q.delete();
    endtask

    task automatic wait_msg(input int target);
        int n = 0;
        while (msg_cnt < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("msg_done_count", 512'(msg_cnt), 512'(target));
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ew[i] = 32'h0;
        reset_n = 0;
        s_data = 0; s_valid = 0; s_last = 0; s_bytes = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", blk_data, 512'd0);
        chk("rst_ctl", {507'b0, s_ready, blk_start, blk_first, blk_last, msg_done}, 512'd0);
        @(posedge clk);
        #1 reset_n = 1;
        repeat (2) @(posedge clk);
        #1;

        // "abc"
        msg_q.push_back(32'h61626300);
        ew[0] = 32'h61626380; ew[15] = 32'h18; push_exp(1, 1);
        send_msg(2'd3, 2'd0, -1);
        wait_msg(1);

        // 56 bytes: 0x80 lands in word 14, length spills to a second block
        for (int i = 0; i < 14; i++) msg_q.push_back(32'hA000_0000 + i);
        for (int i = 0; i < 14; i++) ew[i] = 32'hA000_0000 + i;
        ew[14] = 32'h8000_0000; push_exp(1, 0);
        ew[15] = 32'h1C0; push_exp(0, 1);
        send_msg(2'd0, 2'd0, -1);
        wait_msg(2);

        // 64 bytes: raw block, then 0x80 + length block
        for (int i = 0; i < 16; i++) msg_q.push_back(32'hB000_0000 + i);
        for (int i = 0; i < 16; i++) ew[i] = 32'hB000_0000 + i;
        push_exp(1, 0);
        ew[0] = 32'h8000_0000; ew[15] = 32'h200; push_exp(0, 1);
        send_msg(2'd0, 2'd0, -1);
        wait_msg(3);

        // 66 bytes with s_valid held across the block boundary
        for (int i = 0; i < 16; i++) msg_q.push_back(32'hC000_0000 + i);
        msg_q.push_back(32'hC1C2C3C4);
        for (int i = 0; i < 16; i++) ew[i] = 32'hC000_0000 + i;
        push_exp(1, 0);
        ew[0] = 32'hC1C28000; ew[15] = 32'h210; push_exp(0, 1);
        send_msg(2'd2, 2'd0, -1);
        wait_msg(4);

        // 60 bytes: 0x80 in word 15
        for (int i = 0; i < 15; i++) msg_q.push_back(32'hE000_0000 + i);
        for (int i = 0; i < 15; i++) ew[i] = 32'hE000_0000 + i;
        ew[15] = 32'h8000_0000; push_exp(1, 0);
        ew[15] = 32'h1E0; push_exp(0, 1);
        send_msg(2'd0, 2'd0, -1);
        wait_msg(5);

        // 9 bytes: junk s_bytes on non-last words, spurious blk_done in FILL,
        // garbage below the valid byte of the last word
        msg_q.push_back(32'hD0D1D2D3);
        msg_q.push_back(32'hD4D5D6D7);
        msg_q.push_back(32'hE1FFFFFF);
        ew[0] = 32'hD0D1D2D3; ew[1] = 32'hD4D5D6D7; ew[2] = 32'hE1800000; ew[15] = 32'h48;
        push_exp(1, 1);
        send_msg(2'd1, 2'd2, 1);
        wait_msg(6);

        // Reset while waiting on the core aborts the message
        core_en = 0;
        for (int i = 0; i < 16; i++) msg_q.push_back(32'hF000_0000 + i);
        for (int i = 0; i < 16; i++) ew[i] = 32'hF000_0000 + i;
        push_exp(1, 0);
        send_msg(2'd0, 2'd0, -1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("wait_ready", {511'b0, s_ready}, 512'd0);
        reset_n = 0;
        #1;
        chk("rst_mid_data", blk_data, 512'd0);
        chk("rst_mid_ctl", {507'b0, s_ready, blk_start, blk_first, blk_last, msg_done}, 512'd0);
        @(posedge clk);
        #1 reset_n = 1;
        core_en = 1;
        msg_q.push_back(32'h61620000);
        ew[0] = 32'h61628000; ew[15] = 32'h10; push_exp(1, 1);
        send_msg(2'd2, 2'd0, -1);
        wait_msg(7);

        chk("scoreboard_empty", 512'(exp_q.size()), 512'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
